dcpu16_marb: RTL

Memory arbiter sitting directly downstream of the memory-bus stage: it accepts the two simplified-Wishbone masters (F-BUS: fetch/write-back, G-BUS: operand read) and serialises them onto one single-port synchronous SRAM. It generates `f_ack`/`g_ack` so that the upstream stall term `(f_stb ~^ f_ack) & (g_stb ~^ g_ack)` releases only when every strobed bus has been served. Read data is returned on registered `f_dti`/`g_dti`.

---
 rtl/dcpu16_marb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dcpu16_marb.sv
// dcpu16_marb: serialises the F-BUS (fetch/write-back) and G-BUS (operand read)
// masters onto one single-port synchronous SRAM with a read latency of WAIT cycles.
module dcpu16_marb #(
  parameter int WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] f_adr,
  input  logic        f_stb,
  input  logic        f_wre,
  input  logic [15:0] f_dto,
  output logic [15:0] f_dti,
  output logic        f_ack,
  input  logic [15:0] g_adr,
  input  logic        g_stb,
  input  logic        g_wre,
  output logic [15:0] g_dti,
  output logic        g_ack,
  output logic [15:0] m_adr,
  output logic [15:0] m_dto,
  output logic        m_stb,
  output logic        m_wre,
  input  logic [15:0] m_dti
);

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, FACC, GACC} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        f_rd, f_rd_nxt;
  logic [15:0] m_adr_nxt, m_dto_nxt, f_dti_nxt, g_dti_nxt;
  logic        m_stb_nxt, m_wre_nxt, f_ack_nxt, g_ack_nxt;
  logic        fp, gp, rel, start_f, start_g;
  logic        unused_g_wre;

  // G-BUS is read-only; its write enable is deliberately ignored.
  assign unused_g_wre = g_wre;

  assign fp  = f_stb & ~f_ack;
  assign gp  = g_stb & ~g_ack;
  assign rel = (~f_stb | f_ack) & (~g_stb | g_ack);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    f_rd_nxt  = f_rd;
    m_adr_nxt = m_adr;
    m_dto_nxt = m_dto;
    m_stb_nxt = m_stb;
    m_wre_nxt = m_wre;
    f_dti_nxt = f_dti;
    g_dti_nxt = g_dti;
    f_ack_nxt = f_ack;
    g_ack_nxt = g_ack;
    start_f   = 1'b0;
    start_g   = 1'b0;

    case (state)
      IDLE: begin
        if (rel & (f_ack | g_ack)) begin
          f_ack_nxt = 1'b0;
          g_ack_nxt = 1'b0;
        end else if (fp) begin
          start_f = 1'b1;
        end else if (gp) begin
          start_g = 1'b1;
        end
      end
      FACC, GACC: begin
        if (m_stb) begin
          m_stb_nxt = 1'b0;
          m_wre_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Completion: capture read data, ack, then chain to the other bus if it waits.
            if (state == FACC) begin
              if (f_rd) f_dti_nxt = m_dti;
              f_ack_nxt = 1'b1;
              if (gp) start_g = 1'b1;
              else    state_nxt = IDLE;
            end else begin
              g_dti_nxt = m_dti;
              g_ack_nxt = 1'b1;
              if (fp) start_f = 1'b1;
              else    state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (start_f) begin
      state_nxt = FACC;
      m_adr_nxt = f_adr;
      m_dto_nxt = f_dto;
      m_wre_nxt = f_wre;
      m_stb_nxt = 1'b1;
      cnt_nxt   = WAIT_C;
      f_rd_nxt  = ~f_wre;
    end
    if (start_g) begin
      state_nxt = GACC;
      m_adr_nxt = g_adr;
      m_wre_nxt = 1'b0;
      m_stb_nxt = 1'b1;
      cnt_nxt   = WAIT_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      f_rd  <= 1'b0;
      m_adr <= 16'd0;
      m_dto <= 16'd0;
      m_stb <= 1'b0;
      m_wre <= 1'b0;
      f_dti <= 16'd0;
      g_dti <= 16'd0;
      f_ack <= 1'b0;
      g_ack <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      f_rd  <= f_rd_nxt;
      m_adr <= m_adr_nxt;
      m_dto <= m_dto_nxt;
      m_stb <= m_stb_nxt;
      m_wre <= m_wre_nxt;
      f_dti <= f_dti_nxt;
      g_dti <= g_dti_nxt;
      f_ack <= f_ack_nxt;
      g_ack <= g_ack_nxt;
    end
  end

endmodule
